// File: rtl/spi_target_pkg.sv
// -----------------------------------------------------------------------------
// spi_target_pkg
// Shared constants and types for the spi_target SPI responder: frame geometry,
// status byte bit positions, the frame layout as a packed struct, the FSM
// state enumeration and a helper that assembles the status byte.
// -----------------------------------------------------------------------------
package spi_target_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int ADDR_BITS   = 7;
    localparam int DATA_BITS   = 32;
    localparam int STATUS_BITS = 8;
    localparam int CNT_BITS    = 6;

    // Status byte bit positions.
    localparam int ST_RESET    = 0;
    localparam int ST_LEN_ERR  = 1;
    localparam int ST_ADDR_ERR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // One received frame, MSB first on the wire: write bit, address, data.
    typedef struct packed {
        logic                 write;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    function automatic logic [STATUS_BITS-1:0] status_byte(
        input logic addr_err,
        input logic len_err,
        input logic reset_flag
    );
        logic [STATUS_BITS-1:0] s;
        s              = '0;
        s[ST_ADDR_ERR] = addr_err;
        s[ST_LEN_ERR]  = len_err;
        s[ST_RESET]    = reset_flag;
        return s;
    endfunction

endpackage

// File: rtl/spi_target_if.sv
// -----------------------------------------------------------------------------
// spi_target_if
// SPI pin bundle between an SPI master (or bench) and the spi_target responder.
//   sck_in      master -> target  SPI clock
//   cs_n_in     master -> target  chip select, active low
//   mosi_in     master -> target  serial data towards the target
//   miso_out    target -> master  serial data towards the master, 0 when idle
//   miso_oe_out target -> master  output enable for the board-level tristate
// -----------------------------------------------------------------------------
interface spi_target_if;

    logic sck_in;
    logic cs_n_in;
    logic mosi_in;
    logic miso_out;
    logic miso_oe_out;

    modport master (
        output sck_in,
        output cs_n_in,
        output mosi_in,
        input  miso_out,
        input  miso_oe_out
    );

    modport slave (
        input  sck_in,
        input  cs_n_in,
        input  mosi_in,
        output miso_out,
        output miso_oe_out
    );

endinterface

// File: rtl/spi_target_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for one asynchronous pin plus single-cycle rise/fall
// pulses derived from the synchronized level.
//   clk_in    system clock
//   reset_in  asynchronous active-high reset
//   async_i   asynchronous pin
//   level_o   synchronized level (2 flops behind the pin)
//   rise_o    one-cycle pulse on a synchronized 0->1 transition
//   fall_o    one-cycle pulse on a synchronized 1->0 transition
// A pin edge becomes an acted-upon event on the third clk_in edge.
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk_in,
    input  logic reset_in,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // The whole chain resets low. For chip select this means a CS that is
    // already low when reset releases never produces a falling edge, so a
    // frame in progress at that moment is ignored until CS goes high and
    // falls again.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, as real flops do.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
// SPI responder for 40-bit frames (write bit, 7-bit address, 32-bit data, MSB
// first). Committed frames update a small register file; every frame returns
// {status byte, read data selected by the previous frame} on MISO.
//   clk_in / reset_in   system clock, asynchronous active-high reset
//   spi (slave)         SCK, CS_N, MOSI in; MISO and its output enable out
//   rd_addr_in          side-port register address
//   rd_data_out         combinational reg[rd_addr_in], 0 when out of range
//   frame_valid_out     one-cycle pulse per committed frame
//   frame_write_out     write bit of the last committed frame
//   frame_addr_out      address of the last committed frame
//   frame_data_out      data field of the last committed frame
// -----------------------------------------------------------------------------
module spi_target
    import spi_target_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    spi_target_if.slave          spi,
    input  logic [ADDR_BITS-1:0] rd_addr_in,
    output logic [DATA_BITS-1:0] rd_data_out,
    output logic                 frame_valid_out,
    output logic                 frame_write_out,
    output logic [ADDR_BITS-1:0] frame_addr_out,
    output logic [DATA_BITS-1:0] frame_data_out
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_BITS:0]  NUM_REGS_W = (ADDR_BITS + 1)'(NUM_REGS);
    localparam logic [CNT_BITS-1:0] CNT_FRAME  = CNT_BITS'(FRAME_BITS);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SHIFT  = SHIFT;
    localparam logic [1:0] S_COMMIT = COMMIT;

    // ---------------------------------------------------------------- pins
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_sync;
    logic sck_level_unused;
    logic cs_level_unused;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    sync_edge u_sync_sck (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_i  (spi.sck_in),
        .level_o  (sck_level_unused),
        .rise_o   (sck_rise),
        .fall_o   (sck_fall)
    );

    sync_edge u_sync_cs (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_i  (spi.cs_n_in),
        .level_o  (cs_level_unused),
        .rise_o   (cs_rise),
        .fall_o   (cs_fall)
    );

    sync_edge u_sync_mosi (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_i  (spi.mosi_in),
        .level_o  (mosi_sync),
        .rise_o   (mosi_rise_unused),
        .fall_o   (mosi_fall_unused)
    );

    // ---------------------------------------------------------------- state
    logic [1:0]            state_q,       state_d;
    logic [FRAME_BITS-1:0] tx_shift_q,    tx_shift_d;
    logic [FRAME_BITS-1:0] rx_shift_q,    rx_shift_d;
    logic [CNT_BITS-1:0]   bit_cnt_q,     bit_cnt_d;
    logic [DATA_BITS-1:0]  rdata_latch_q, rdata_latch_d;
    logic                  reset_flag_q,  reset_flag_d;
    logic                  len_err_q,     len_err_d;
    logic                  addr_err_q,    addr_err_d;
    logic                  cs_pend_q,     cs_pend_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_write_q, frame_write_d;
    logic [ADDR_BITS-1:0]  frame_addr_q,  frame_addr_d;
    logic [DATA_BITS-1:0]  frame_data_q,  frame_data_d;

    logic [DATA_BITS-1:0]  regs_q [NUM_REGS];
    logic                  reg_we;

    frame_t                rx_frame;
    logic                  rx_addr_ok;
    logic [IDX_W-1:0]      rx_idx;

    assign rx_frame   = rx_shift_q;
    assign rx_addr_ok = {1'b0, rx_frame.addr} < NUM_REGS_W;
    assign rx_idx     = rx_frame.addr[IDX_W-1:0];

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        rdata_latch_d = rdata_latch_q;
        reset_flag_d  = reset_flag_q;
        len_err_d     = len_err_q;
        addr_err_d    = addr_err_q;
        cs_pend_d     = cs_pend_q;
        frame_valid_d = 1'b0;
        frame_write_d = frame_write_q;
        frame_addr_d  = frame_addr_q;
        frame_data_d  = frame_data_q;
        reg_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A CS fall seen during COMMIT is remembered and taken here.
                if (cs_fall || cs_pend_q) begin
                    state_d    = S_SHIFT;
                    tx_shift_d = {status_byte(addr_err_q, len_err_q, reset_flag_q),
                                  rdata_latch_q};
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    cs_pend_d  = 1'b0;
                end
            end

            S_SHIFT: begin
                // CS rising wins over a coincident SCK edge.
                if (cs_rise) begin
                    state_d = S_COMMIT;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_sync};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // A falling edge before any rising edge is the mode 3
                    // leading edge; the first bit must still be presented.
                    if (sck_fall && (bit_cnt_q != '0)) begin
                        tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
                if (cs_fall) begin
                    cs_pend_d = 1'b1;
                end
                if (bit_cnt_q == CNT_FRAME) begin
                    frame_valid_d = 1'b1;
                    frame_write_d = rx_frame.write;
                    frame_addr_d  = rx_frame.addr;
                    frame_data_d  = rx_frame.data;
                    if (rx_addr_ok) begin
                        if (rx_frame.write) begin
                            reg_we        = 1'b1;
                            rdata_latch_d = rx_frame.data;
                        end else begin
                            rdata_latch_d = regs_q[rx_idx];
                        end
                    end else begin
                        rdata_latch_d = '0;
                    end
                    addr_err_d   = ~rx_addr_ok;
                    len_err_d    = 1'b0;
                    reset_flag_d = 1'b0;
                end else begin
                    len_err_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= S_IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            rdata_latch_q <= '0;
            reset_flag_q  <= 1'b1;
            len_err_q     <= 1'b0;
            addr_err_q    <= 1'b0;
            cs_pend_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_write_q <= 1'b0;
            frame_addr_q  <= '0;
            frame_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            rdata_latch_q <= rdata_latch_d;
            reset_flag_q  <= reset_flag_d;
            len_err_q     <= len_err_d;
            addr_err_q    <= addr_err_d;
            cs_pend_q     <= cs_pend_d;
            frame_valid_q <= frame_valid_d;
            frame_write_q <= frame_write_d;
            frame_addr_q  <= frame_addr_d;
            frame_data_q  <= frame_data_d;
        end
    end

    // ---------------------------------------------------------- register file
    // NOTE: this array is architectural state visible on the side port and
    // must come out of reset at a known value, so it is reset explicitly
    // rather than left as an uninitialised memory.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else if (reg_we) begin
            regs_q[rx_idx] <= rx_frame.data;
        end
    end

    logic rd_in_range;
    assign rd_in_range = {1'b0, rd_addr_in} < NUM_REGS_W;
    assign rd_data_out = rd_in_range ? regs_q[rd_addr_in[IDX_W-1:0]] : '0;

    // ---------------------------------------------------------------- outputs
    assign spi.miso_oe_out = (state_q == S_SHIFT);
    assign spi.miso_out    = (state_q == S_SHIFT) & tx_shift_q[FRAME_BITS-1];

    assign frame_valid_out = frame_valid_q;
    assign frame_write_out = frame_write_q;
    assign frame_addr_out  = frame_addr_q;
    assign frame_data_out  = frame_data_q;

endmodule
